// File: rtl/div_reservation_station.sv
// Reservation station in front of div_unit: holds dispatched divide ops, snoops the CDB/XER buses, issues ready ops lowest slot first.
// Optional DIV_RS_BYPASS_EN: a dispatching operand also captures a matching same-cycle broadcast.
package div_pkg;
    typedef struct packed {
        logic is_signed;
        logic is_modulus;
        logic is_extended;
        logic is_32bit;
        logic set_ov;
        logic set_cr0;
    } div_decode_t;
endpackage

module div_reservation_station
    import div_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_OFFSET   = 0,
    parameter int RS_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [4:0]             dispatch_result_reg_addr,
    input  div_decode_t            dispatch_control,
    input  logic                   dispatch_op1_valid,
    input  logic                   dispatch_op2_valid,
    input  logic                   dispatch_xer_valid,
    input  logic [31:0]            dispatch_op1,
    input  logic [31:0]            dispatch_op2,
    input  logic [31:0]            dispatch_xer,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,
    input  logic                   xer_bus_valid,
    input  logic [RS_ID_WIDTH-1:0] xer_bus_rs_id,
    input  logic [31:0]            xer_bus_value,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [31:0]            op1_out,
    output logic [31:0]            op2_out,
    output logic [31:0]            xer_out,
    output div_decode_t            control_out
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    typedef logic [RS_ID_WIDTH-1:0] tag_t;

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_READY   = 2'd2,
        ST_ISSUED  = 2'd3
    } entry_state_t;

    // A pending operand carries its producer tag in bit indices 32-RS_ID_WIDTH..31.
    typedef struct packed {
        entry_state_t state;
        logic [4:0]   rd;
        div_decode_t  ctrl;
        logic         op1_v;
        logic         op2_v;
        logic         xer_v;
        logic [31:0]  op1;
        logic [31:0]  op2;
        logic [31:0]  xer;
    } entry_t;

    typedef struct packed {
        logic        valid;
        tag_t        rs_id;
        logic [4:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] xer;
        div_decode_t ctrl;
    } issue_t;

    entry_t           entry_q [RS_DEPTH];
    entry_t           entry_d [RS_DEPTH];
    issue_t           issue_q;
    issue_t           issue_d;
    entry_t           new_entry;
    logic             free_found;
    logic             ready_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] ready_idx;
    tag_t             ready_tag;
    logic             dispatch_fire;
    logic             issue_load;
    logic             issue_fire;

    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        ready_tag   = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (!free_found && entry_q[i].state == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!ready_found && entry_q[i].state == ST_READY) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
                ready_tag   = tag_t'(RS_OFFSET + i);
            end
        end
    end

    assign dispatch_ready = free_found;
    assign dispatch_fire  = dispatch_valid && free_found;
    assign issue_load     = !issue_q.valid || output_ready;
    assign issue_fire     = issue_load && ready_found;

    always_comb begin
        new_entry.state = ST_WAITING;
        new_entry.rd    = dispatch_result_reg_addr;
        new_entry.ctrl  = dispatch_control;
        new_entry.op1_v = dispatch_op1_valid;
        new_entry.op2_v = dispatch_op2_valid;
        new_entry.xer_v = dispatch_xer_valid;
        new_entry.op1   = dispatch_op1;
        new_entry.op2   = dispatch_op2;
        new_entry.xer   = dispatch_xer;
`ifdef DIV_RS_BYPASS_EN
        if (!dispatch_op1_valid && cdb_valid && cdb_rs_id == dispatch_op1[31 -: RS_ID_WIDTH]) begin
            new_entry.op1   = cdb_result;
            new_entry.op1_v = 1'b1;
        end
        if (!dispatch_op2_valid && cdb_valid && cdb_rs_id == dispatch_op2[31 -: RS_ID_WIDTH]) begin
            new_entry.op2   = cdb_result;
            new_entry.op2_v = 1'b1;
        end
        if (!dispatch_xer_valid && xer_bus_valid && xer_bus_rs_id == dispatch_xer[31 -: RS_ID_WIDTH]) begin
            new_entry.xer   = xer_bus_value;
            new_entry.xer_v = 1'b1;
        end
`endif
        if (new_entry.op1_v && new_entry.op2_v && new_entry.xer_v) begin
            new_entry.state = ST_READY;
        end
    end

    always_comb begin
        entry_d = entry_q;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            case (entry_q[i].state)
                ST_FREE: begin
                    if (dispatch_fire && free_idx == IDX_W'(i)) begin
                        entry_d[i] = new_entry;
                    end
                end
                ST_WAITING: begin
                    if (!entry_q[i].op1_v && cdb_valid && cdb_rs_id == entry_q[i].op1[31 -: RS_ID_WIDTH]) begin
                        entry_d[i].op1   = cdb_result;
                        entry_d[i].op1_v = 1'b1;
                    end
                    if (!entry_q[i].op2_v && cdb_valid && cdb_rs_id == entry_q[i].op2[31 -: RS_ID_WIDTH]) begin
                        entry_d[i].op2   = cdb_result;
                        entry_d[i].op2_v = 1'b1;
                    end
                    if (!entry_q[i].xer_v && xer_bus_valid && xer_bus_rs_id == entry_q[i].xer[31 -: RS_ID_WIDTH]) begin
                        entry_d[i].xer   = xer_bus_value;
                        entry_d[i].xer_v = 1'b1;
                    end
                    if (entry_d[i].op1_v && entry_d[i].op2_v && entry_d[i].xer_v) begin
                        entry_d[i].state = ST_READY;
                    end
                end
                ST_READY: begin
                    if (issue_fire && ready_idx == IDX_W'(i)) begin
                        entry_d[i].state = ST_ISSUED;
                    end
                end
                ST_ISSUED: begin
                    // Stays allocated until div_unit broadcasts this slot's own tag.
                    if (cdb_valid && cdb_rs_id == tag_t'(RS_OFFSET + i)) begin
                        entry_d[i].state = ST_FREE;
                    end
                end
                default: entry_d[i].state = ST_FREE;
            endcase
        end
    end

    always_comb begin
        issue_d = issue_q;
        if (issue_load) begin
            issue_d.valid = ready_found;
            if (ready_found) begin
                issue_d.rs_id = ready_tag;
                issue_d.rd    = entry_q[ready_idx].rd;
                issue_d.op1   = entry_q[ready_idx].op1;
                issue_d.op2   = entry_q[ready_idx].op2;
                issue_d.xer   = entry_q[ready_idx].xer;
                issue_d.ctrl  = entry_q[ready_idx].ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            issue_q <= '0;
        end else begin
            entry_q <= entry_d;
            issue_q <= issue_d;
        end
    end

    assign output_valid        = issue_q.valid;
    assign rs_id_out           = issue_q.rs_id;
    assign result_reg_addr_out = issue_q.rd;
    assign op1_out             = issue_q.op1;
    assign op2_out             = issue_q.op2;
    assign xer_out             = issue_q.xer;
    assign control_out         = issue_q.ctrl;
endmodule

// File: tb/tb_div_reservation_station.sv
// Self-checking bench for div_reservation_station: directed scenarios plus a randomized in-order issue scoreboard.
module tb_div_reservation_station;
    import div_pkg::*;

    localparam int W     = 5;
    localparam int OFF   = 0;
    localparam int DEPTH = 4;
    localparam int CW    = $bits(div_decode_t);

    logic        clk = 1'b0;
    logic        rst;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [4:0]  dispatch_result_reg_addr;
    div_decode_t dispatch_control;
    logic        dispatch_op1_valid, dispatch_op2_valid, dispatch_xer_valid;
    logic [31:0] dispatch_op1, dispatch_op2, dispatch_xer;
    logic        cdb_valid;
    logic [W-1:0] cdb_rs_id;
    logic [31:0] cdb_result;
    logic        xer_bus_valid;
    logic [W-1:0] xer_bus_rs_id;
    logic [31:0] xer_bus_value;
    logic        output_valid;
    logic        output_ready;
    logic [W-1:0] rs_id_out;
    logic [4:0]  result_reg_addr_out;
    logic [31:0] op1_out, op2_out, xer_out;
    div_decode_t control_out;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [W-1:0] tag;
        logic [4:0]   rd;
        logic [31:0]  op1;
        logic [31:0]  op2;
        logic [31:0]  xer;
        div_decode_t  ctrl;
    } exp_t;

    div_reservation_station #(.RS_ID_WIDTH(W), .RS_OFFSET(OFF), .RS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_result_reg_addr(dispatch_result_reg_addr), .dispatch_control(dispatch_control),
        .dispatch_op1_valid(dispatch_op1_valid), .dispatch_op2_valid(dispatch_op2_valid),
        .dispatch_xer_valid(dispatch_xer_valid),
        .dispatch_op1(dispatch_op1), .dispatch_op2(dispatch_op2), .dispatch_xer(dispatch_xer),
        .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
        .xer_bus_valid(xer_bus_valid), .xer_bus_rs_id(xer_bus_rs_id), .xer_bus_value(xer_bus_value),
        .output_valid(output_valid), .output_ready(output_ready),
        .rs_id_out(rs_id_out), .result_reg_addr_out(result_reg_addr_out),
        .op1_out(op1_out), .op2_out(op2_out), .xer_out(xer_out), .control_out(control_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pend(input int tag);
        return 32'(tag) << (32 - W);
    endfunction

    task automatic idle();
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
        xer_bus_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        dispatch_result_reg_addr = '0;
        dispatch_control = '0;
        {dispatch_op1_valid, dispatch_op2_valid, dispatch_xer_valid} = '0;
        {dispatch_op1, dispatch_op2, dispatch_xer} = '0;
        cdb_rs_id = '0; cdb_result = '0;
        xer_bus_rs_id = '0; xer_bus_value = '0;
        output_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic dispatch_set(input logic [31:0] a, input logic av, input logic [31:0] b, input logic bv,
                                input logic [31:0] x, input logic xv, input logic [4:0] rd, input div_decode_t c);
        dispatch_valid = 1'b1;
        dispatch_op1 = a; dispatch_op1_valid = av;
        dispatch_op2 = b; dispatch_op2_valid = bv;
        dispatch_xer = x; dispatch_xer_valid = xv;
        dispatch_result_reg_addr = rd;
        dispatch_control = c;
    endtask

    task automatic test_reset();
        do_reset();
        output_ready = 1'b0;
        dispatch_set(32'd55, 1'b1, 32'd5, 1'b1, 32'h8000_0000, 1'b1, 5'd9, 6'h3f);
        step();
        dispatch_valid = 1'b0;
        step();
        n_checks++;
        if (output_valid !== 1'b1) $display("FAIL pre_reset_valid: got %0b expected 1", output_valid); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (output_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", output_valid); else n_pass++;
        n_checks++;
        if ({rs_id_out, result_reg_addr_out, op1_out, op2_out, xer_out, control_out} !== '0)
            $display("FAIL reset_outputs: got id=%0d rd=%0d op1=%h op2=%h xer=%h ctrl=%h expected all 0",
                     rs_id_out, result_reg_addr_out, op1_out, op2_out, xer_out, control_out);
        else n_pass++;
        n_checks++;
        if (dispatch_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", dispatch_ready); else n_pass++;
        output_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (output_valid !== 1'b0) $display("FAIL reset_discard: got %0b expected 0", output_valid); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        dispatch_set(32'd100, 1'b1, 32'd7, 1'b1, 32'd0, 1'b1, 5'd3, 6'h15);
        step();
        dispatch_valid = 1'b0;
        n_checks++;
        if (output_valid !== 1'b0) $display("FAIL basic_c1_valid: got %0b expected 0", output_valid); else n_pass++;
        step();
        n_checks++;
        if (output_valid !== 1'b1) $display("FAIL basic_c2_valid: got %0b expected 1", output_valid); else n_pass++;
        n_checks++;
        if ({rs_id_out, result_reg_addr_out, op1_out, op2_out, xer_out, control_out} !==
            {W'(OFF), 5'd3, 32'd100, 32'd7, 32'd0, 6'h15})
            $display("FAIL basic_data: got id=%0d rd=%0d op1=%0d op2=%0d xer=%0d ctrl=%h expected id=%0d rd=3 op1=100 op2=7 xer=0 ctrl=15",
                     rs_id_out, result_reg_addr_out, op1_out, op2_out, xer_out, control_out, OFF);
        else n_pass++;
        step();
        n_checks++;
        if (output_valid !== 1'b0) $display("FAIL basic_c3_valid: got %0b expected 0", output_valid); else n_pass++;
    endtask

    task automatic test_snoop();
        do_reset();
        dispatch_set(32'd50, 1'b1, pend(9), 1'b0, 32'd0, 1'b1, 5'd4, 6'h01);
        for (int c = 1; c <= 6; c++) begin
            step();
            dispatch_valid = 1'b0;
            cdb_valid  = (c == 4);
            cdb_rs_id  = W'(9);
            cdb_result = 32'd3;
            n_checks++;
            if (output_valid !== (c == 6))
                $display("FAIL snoop_valid_c%0d: got %0b expected %0b", c, output_valid, (c == 6));
            else n_pass++;
        end
        n_checks++;
        if (op2_out !== 32'd3 || op1_out !== 32'd50)
            $display("FAIL snoop_data: got op1=%0d op2=%0d expected op1=50 op2=3", op1_out, op2_out);
        else n_pass++;
        cdb_valid = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        output_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            dispatch_set(32'(1000 + k), 1'b1, 32'(20 + k), 1'b1, 32'(k), 1'b1, 5'(k), 6'h02);
            step();
        end
        dispatch_set(32'd9999, 1'b1, 32'd1, 1'b1, 32'd0, 1'b1, 5'd31, 6'h04);
        n_checks++;
        if (dispatch_ready !== 1'b0) $display("FAIL full_ready: got %0b expected 0", dispatch_ready); else n_pass++;
        step();
        step();
        n_checks++;
        if (output_valid !== 1'b1 || rs_id_out !== W'(OFF) || op1_out !== 32'd1000)
            $display("FAIL full_hold: got v=%0b id=%0d op1=%0d expected v=1 id=%0d op1=1000",
                     output_valid, rs_id_out, op1_out, OFF);
        else n_pass++;
        output_ready = 1'b1;
        for (int k = 1; k < DEPTH; k++) begin
            step();
            n_checks++;
            if (output_valid !== 1'b1 || rs_id_out !== W'(OFF + k) || op1_out !== 32'(1000 + k))
                $display("FAIL full_order_%0d: got v=%0b id=%0d op1=%0d expected v=1 id=%0d op1=%0d",
                         k, output_valid, rs_id_out, op1_out, OFF + k, 1000 + k);
            else n_pass++;
        end
        step();
        n_checks++;
        if (output_valid !== 1'b0 || dispatch_ready !== 1'b0)
            $display("FAIL full_drain: got v=%0b ready=%0b expected v=0 ready=0", output_valid, dispatch_ready);
        else n_pass++;
    endtask

    // Continues from test_full: all slots issued, upstream still holding op1=9999.
    task automatic test_release();
        cdb_valid  = 1'b1;
        cdb_rs_id  = W'(OFF);
        cdb_result = $urandom;
        n_checks++;
        if (dispatch_ready !== 1'b0) $display("FAIL release_same_cycle: got %0b expected 0", dispatch_ready); else n_pass++;
        step();
        cdb_valid = 1'b0;
        n_checks++;
        if (dispatch_ready !== 1'b1) $display("FAIL release_ready: got %0b expected 1", dispatch_ready); else n_pass++;
        step();
        dispatch_valid = 1'b0;
        n_checks++;
        if (dispatch_ready !== 1'b0) $display("FAIL release_refull: got %0b expected 0", dispatch_ready); else n_pass++;
        step();
        n_checks++;
        if (output_valid !== 1'b1 || rs_id_out !== W'(OFF) || op1_out !== 32'd9999)
            $display("FAIL release_slot0: got v=%0b id=%0d op1=%0d expected v=1 id=%0d op1=9999",
                     output_valid, rs_id_out, op1_out, OFF);
        else n_pass++;
    endtask

    task automatic test_multi_snoop();
        do_reset();
        dispatch_set(pend(20), 1'b0, 32'd1, 1'b1, 32'd0, 1'b1, 5'd1, 6'h00);
        step();
        dispatch_set(pend(12), 1'b0, 32'd11, 1'b1, 32'd0, 1'b1, 5'd2, 6'h00);
        step();
        dispatch_set(32'd200, 1'b1, pend(12), 1'b0, 32'd0, 1'b1, 5'd3, 6'h00);
        step();
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_rs_id = W'(12); cdb_result = 32'd777;
        n_checks++;
        if (output_valid !== 1'b0) $display("FAIL multi_c3_valid: got %0b expected 0", output_valid); else n_pass++;
        step();
        cdb_valid = 1'b0;
        n_checks++;
        if (output_valid !== 1'b0) $display("FAIL multi_c4_valid: got %0b expected 0", output_valid); else n_pass++;
        step();
        n_checks++;
        if (output_valid !== 1'b1 || rs_id_out !== W'(OFF + 1) || op1_out !== 32'd777 || op2_out !== 32'd11)
            $display("FAIL multi_first: got v=%0b id=%0d op1=%0d op2=%0d expected v=1 id=%0d op1=777 op2=11",
                     output_valid, rs_id_out, op1_out, op2_out, OFF + 1);
        else n_pass++;
        step();
        n_checks++;
        if (output_valid !== 1'b1 || rs_id_out !== W'(OFF + 2) || op1_out !== 32'd200 || op2_out !== 32'd777)
            $display("FAIL multi_second: got v=%0b id=%0d op1=%0d op2=%0d expected v=1 id=%0d op1=200 op2=777",
                     output_valid, rs_id_out, op1_out, op2_out, OFF + 2);
        else n_pass++;
        step();
        n_checks++;
        if (output_valid !== 1'b0) $display("FAIL multi_entry0_waits: got %0b expected 0", output_valid); else n_pass++;
    endtask

    task automatic test_bypass();
        do_reset();
        dispatch_set(pend(5), 1'b0, 32'd6, 1'b1, 32'd0, 1'b1, 5'd7, 6'h08);
        cdb_valid = 1'b1; cdb_rs_id = W'(5); cdb_result = 32'd42;
        step();
        idle();
`ifdef DIV_RS_BYPASS_EN
        step();
        n_checks++;
        if (output_valid !== 1'b1 || op1_out !== 32'd42)
            $display("FAIL bypass_issue: got v=%0b op1=%0d expected v=1 op1=42", output_valid, op1_out);
        else n_pass++;
`else
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (output_valid !== 1'b0) $display("FAIL nobypass_wait_c%0d: got %0b expected 0", c, output_valid);
            else n_pass++;
            step();
        end
        cdb_valid = 1'b1; cdb_rs_id = W'(5); cdb_result = 32'd43;
        step();
        cdb_valid = 1'b0;
        n_checks++;
        if (output_valid !== 1'b0) $display("FAIL nobypass_c6: got %0b expected 0", output_valid); else n_pass++;
        step();
        n_checks++;
        if (output_valid !== 1'b1 || op1_out !== 32'd43)
            $display("FAIL nobypass_issue: got v=%0b op1=%0d expected v=1 op1=43", output_valid, op1_out);
        else n_pass++;
`endif
    endtask

    // From a fresh reset with no releases, slots fill in dispatch order, so issue order equals dispatch order.
    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            exp_t q[$];
            exp_t e;
            exp_t got;
            int   n;
            int   sent;
            int   budget;
            do_reset();
            n = $urandom_range(1, DEPTH);
            sent = 0;
            budget = 0;
            while ((sent < n || q.size() > 0) && budget < 80) begin
                dispatch_valid = 1'b0;
                if (sent < n && $urandom_range(0, 2) != 0) begin
                    e.tag  = W'(OFF + sent);
                    e.rd   = 5'($urandom);
                    e.op1  = $urandom;
                    e.op2  = $urandom;
                    e.xer  = $urandom;
                    e.ctrl = CW'($urandom);
                    dispatch_set(e.op1, 1'b1, e.op2, 1'b1, e.xer, 1'b1, e.rd, e.ctrl);
                    n_checks++;
                    if (dispatch_ready !== 1'b1) $display("FAIL rand_ready: got %0b expected 1", dispatch_ready);
                    else begin
                        n_pass++;
                        q.push_back(e);
                        sent++;
                    end
                end
                output_ready = 1'($urandom_range(0, 1));
                if (output_valid === 1'b1 && output_ready) begin
                    got = {rs_id_out, result_reg_addr_out, op1_out, op2_out, xer_out, control_out};
                    n_checks++;
                    if (q.size() == 0) $display("FAIL rand_unexpected_issue: got %h expected none", got);
                    else begin
                        e = q.pop_front();
                        if (got !== e) $display("FAIL rand_issue: got %h expected %h", got, e);
                        else n_pass++;
                    end
                end
                step();
                budget++;
            end
            n_checks++;
            if (q.size() != 0 || sent < n)
                $display("FAIL rand_timeout: got %0d pending %0d unsent expected 0 0", q.size(), n - sent);
            else n_pass++;
        end
        idle();
        output_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        output_ready = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_snoop();
        test_full();
        test_release();
        test_multi_snoop();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
